mode_select_ctrl: RTL and testbench

Front-panel mode controller that drives the 3-bit `mode_state` bus consumed by the seven-segment mode-name display and by the mode datapaths.
- Synchronizes and debounces two push-buttons (confirm, back).
- Samples a 3-bit switch selector.
- Runs the top-level mode state machine: DEFAULT, STORE, GEN, SHOW, CALC, SETUP.
- Accepts a busy/done handshake from whichever mode datapath is active.

---
 rtl/mode_select_ctrl_if.sv | 22 ++
 rtl/mode_select_ctrl.sv | 99 +++++++++
 tb/tb_mode_select_ctrl.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mode_select_ctrl_if.sv
// Front-panel bundle between the panel (buttons, selector, datapath handshake) and the mode controller.
// master drives the raw panel inputs and datapath status; slave is the controller that reports the mode.
interface mode_select_ctrl_if;
    logic       btn_confirm;
    logic       btn_back;
    logic [2:0] sw_sel;
    logic       mode_busy;
    logic       mode_done;
    logic [2:0] mode_state;
    logic       mode_enter;
    logic       sel_err;

    modport master (
        output btn_confirm, btn_back, sw_sel, mode_busy, mode_done,
        input  mode_state, mode_enter, sel_err
    );

    modport slave (
        input  btn_confirm, btn_back, sw_sel, mode_busy, mode_done,
        output mode_state, mode_enter, sel_err
    );
endinterface

// File: rtl/mode_select_ctrl.sv
// Front-panel mode controller: sync + debounce buttons, then run the DEFAULT/STORE/GEN/SHOW/CALC/SETUP FSM.
// Button-to-mode latency is DEBOUNCE_CYCLES+3 edges; mode_done acts on the next edge; no backpressure.
module mode_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    mode_select_ctrl_if.slave bus
);
    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_DEFAULT = 3'd0,
        ST_STORE   = 3'd1,
        ST_GEN     = 3'd2,
        ST_SHOW    = 3'd3,
        ST_CALC    = 3'd4,
        ST_SETUP   = 3'd5
    } state_t;

    // Bit 0 is confirm, bit 1 is back throughout the button front end.
    logic [1:0]       btn_s1;
    logic [1:0]       btn_s2;
    logic [1:0]       db;
    logic [1:0]       db_q;
    logic [1:0]       press;
    logic [1:0][23:0] cnt;
    logic [2:0]       sel_s1;
    logic [2:0]       sel_s2;

    state_t state;
    logic   mode_enter_r;
    logic   sel_err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            db     <= '0;
            db_q   <= '0;
            press  <= '0;
            cnt    <= '0;
            sel_s1 <= '0;
            sel_s2 <= '0;
        end else begin
            btn_s1 <= {bus.btn_back, bus.btn_confirm};
            btn_s2 <= btn_s1;
            sel_s1 <= bus.sw_sel;
            sel_s2 <= sel_s1;
            // A level is accepted only after it differs from db on DEBOUNCE_CYCLES consecutive edges.
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= btn_s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 24'd1;
                end
            end
            db_q  <= db;
            press <= db & ~db_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_DEFAULT;
            mode_enter_r <= 1'b0;
            sel_err_r    <= 1'b0;
        end else begin
            mode_enter_r <= 1'b0;
            sel_err_r    <= 1'b0;
            case (state)
                ST_DEFAULT: begin
                    if (press[0]) begin
                        if (sel_s2 >= 3'd1 && sel_s2 <= 3'd5) begin
                            state        <= state_t'(sel_s2);
                            mode_enter_r <= 1'b1;
                        end else begin
                            sel_err_r <= 1'b1;
                        end
                    end
                end
                ST_STORE, ST_GEN, ST_SHOW, ST_CALC, ST_SETUP: begin
                    // A back press while busy is simply lost; done always wins.
                    if (bus.mode_done || (press[1] && !bus.mode_busy)) begin
                        state <= ST_DEFAULT;
                    end
                end
                default: state <= ST_DEFAULT;
            endcase
        end
    end

    assign bus.mode_state = state;
    assign bus.mode_enter = mode_enter_r;
    assign bus.sel_err    = sel_err_r;
endmodule

// File: tb/tb_mode_select_ctrl.sv
// Self-checking bench for mode_select_ctrl: directed scenarios plus random panel activity vs a history-based model.
module tb_mode_select_ctrl;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mode_select_ctrl_if bus();

    mode_select_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: buttons are seen two edges late, a level is accepted once the
    // last DC seen samples all disagree with the accepted level, a press is a rise of
    // the accepted level, and the mode rules act on the press one edge later.
    bit         md_raw  [2][2];
    logic [2:0] md_sel  [2];
    bit         md_hist [2][DC];
    bit         md_acc  [2];
    bit         md_accp [2];
    bit         md_press[2];
    int         md_mode;
    bit         md_enter;
    bit         md_err;

    always @(posedge clk) begin
        bit         raw_now [2];
        bit         seen_i;
        bit         flip;
        logic [2:0] sel_seen;
        raw_now[0] = bus.btn_confirm;
        raw_now[1] = bus.btn_back;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                md_raw[i][0] = 1'b0;
                md_raw[i][1] = 1'b0;
                for (int k = 0; k < DC; k++) md_hist[i][k] = 1'b0;
                md_acc[i]   = 1'b0;
                md_accp[i]  = 1'b0;
                md_press[i] = 1'b0;
            end
            md_sel[0] = 3'd0;
            md_sel[1] = 3'd0;
            md_mode   = 0;
            md_enter  = 1'b0;
            md_err    = 1'b0;
        end else begin
            sel_seen  = md_sel[0];
            md_sel[0] = md_sel[1];
            md_sel[1] = bus.sw_sel;
            md_enter  = 1'b0;
            md_err    = 1'b0;
            if (md_mode == 0) begin
                if (md_press[0]) begin
                    if (sel_seen >= 3'd1 && sel_seen <= 3'd5) begin
                        md_mode  = int'(sel_seen);
                        md_enter = 1'b1;
                    end else begin
                        md_err = 1'b1;
                    end
                end
            end else if (bus.mode_done || (md_press[1] && !bus.mode_busy)) begin
                md_mode = 0;
            end
            for (int i = 0; i < 2; i++) begin
                seen_i       = md_raw[i][0];
                md_raw[i][0] = md_raw[i][1];
                md_raw[i][1] = raw_now[i];
                md_press[i]  = md_acc[i] & ~md_accp[i];
                md_accp[i]   = md_acc[i];
                for (int k = 0; k < DC - 1; k++) md_hist[i][k] = md_hist[i][k+1];
                md_hist[i][DC-1] = seen_i;
                flip = 1'b1;
                for (int k = 0; k < DC; k++) if (md_hist[i][k] == md_acc[i]) flip = 1'b0;
                if (flip) md_acc[i] = ~md_acc[i];
            end
        end
    end

    function automatic logic [4:0] dut_vec();
        return {bus.mode_state, bus.mode_enter, bus.sel_err};
    endfunction

    function automatic logic [4:0] mdl_vec();
        return {3'(md_mode), md_enter, md_err};
    endfunction

    // Model-tracking tally between directed checkpoints.
    int         mm = 0;
    logic [4:0] mm_act;
    logic [4:0] mm_exp;

    task automatic step();
        @(posedge clk);
        #1;
        if (dut_vec() !== mdl_vec()) begin
            if (mm == 0) begin
                mm_act = dut_vec();
                mm_exp = mdl_vec();
            end
            mm++;
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic hold_btn(input bit back, input int n);
        if (back) bus.btn_back = 1'b1; else bus.btn_confirm = 1'b1;
        steps(n);
        if (back) bus.btn_back = 1'b0; else bus.btn_confirm = 1'b0;
    endtask

    task automatic enter_mode(input logic [2:0] m);
        bus.sw_sel = m;
        steps(3);
        hold_btn(1'b0, 6);
        steps(8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        steps(3);
        checks++;
        if (dut_vec() !== 5'b0) begin
            errors++;
            $display("FAIL reset_vals: got {state,enter,err}=%b, want 00000", dut_vec());
        end
        rst = 1'b0;
        mm  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (dut_vec() !== 5'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %b, want 00000", i, dut_vec());
            end
        end
    endtask

    task automatic test_legal_entry();
        int enters;
        bus.sw_sel = 3'd3;
        steps(3);
        bus.btn_confirm = 1'b1;
        steps(7);
        checks++;
        if (bus.mode_state !== 3'd0 || bus.mode_enter !== 1'b0) begin
            errors++;
            $display("FAIL entry_edge6: state=%0d enter=%0b, want 0/0", bus.mode_state, bus.mode_enter);
        end
        step();
        checks++;
        if (bus.mode_state !== 3'd3 || bus.mode_enter !== 1'b1) begin
            errors++;
            $display("FAIL entry_edge7: state=%0d enter=%0b, want 3/1", bus.mode_state, bus.mode_enter);
        end
        step();
        checks++;
        if (bus.mode_state !== 3'd3 || bus.mode_enter !== 1'b0) begin
            errors++;
            $display("FAIL entry_edge8: state=%0d enter=%0b, want 3/0", bus.mode_state, bus.mode_enter);
        end
        enters = 0;
        step();
        enters += int'(bus.mode_enter);
        bus.btn_confirm = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            enters += int'(bus.mode_enter);
        end
        checks++;
        if (enters !== 0 || bus.mode_state !== 3'd3) begin
            errors++;
            $display("FAIL entry_no_repeat: extra enters=%0d state=%0d, want 0 and 3", enters, bus.mode_state);
        end
        hold_btn(1'b1, 6);
        steps(6);
        checks++;
        if (bus.mode_state !== 3'd0) begin
            errors++;
            $display("FAIL back_to_default: state=%0d, want 0", bus.mode_state);
        end
        checks++;
        if (mm !== 0) begin
            errors++;
            $display("FAIL model_legal_entry: %0d cycles off, first act=%b exp=%b", mm, mm_act, mm_exp);
        end
        mm = 0;
    endtask

    task automatic test_glitch_illegal();
        int moved;
        int errs;
        moved = 0;
        hold_btn(1'b0, 3);
        step();
        hold_btn(1'b0, 3);
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.mode_state !== 3'd0 || bus.mode_enter !== 1'b0) moved++;
        end
        checks++;
        if (moved !== 0 || bus.mode_state !== 3'd0) begin
            errors++;
            $display("FAIL glitch_reject: %0d cycles left DEFAULT, state=%0d, want 0", moved, bus.mode_state);
        end
        bus.sw_sel = 3'd6;
        steps(3);
        bus.btn_confirm = 1'b1;
        steps(7);
        checks++;
        if (bus.sel_err !== 1'b0) begin
            errors++;
            $display("FAIL sel_err_early: sel_err=%0b at edge 6, want 0", bus.sel_err);
        end
        step();
        checks++;
        if (bus.sel_err !== 1'b1 || bus.mode_state !== 3'd0 || bus.mode_enter !== 1'b0) begin
            errors++;
            $display("FAIL sel_err_edge7: err=%0b state=%0d enter=%0b, want 1/0/0",
                     bus.sel_err, bus.mode_state, bus.mode_enter);
        end
        errs = 0;
        step();
        errs += int'(bus.sel_err);
        step();
        errs += int'(bus.sel_err);
        bus.btn_confirm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            errs += int'(bus.sel_err);
        end
        checks++;
        if (errs !== 0 || bus.mode_state !== 3'd0) begin
            errors++;
            $display("FAIL sel_err_once: extra pulses=%0d state=%0d, want 0 and 0", errs, bus.mode_state);
        end
        checks++;
        if (mm !== 0) begin
            errors++;
            $display("FAIL model_glitch: %0d cycles off, first act=%b exp=%b", mm, mm_act, mm_exp);
        end
        mm = 0;
    endtask

    task automatic test_busy_back();
        enter_mode(3'd4);
        checks++;
        if (bus.mode_state !== 3'd4) begin
            errors++;
            $display("FAIL busy_enter: state=%0d, want 4", bus.mode_state);
        end
        bus.mode_busy = 1'b1;
        hold_btn(1'b1, 6);
        steps(8);
        checks++;
        if (bus.mode_state !== 3'd4) begin
            errors++;
            $display("FAIL busy_blocks: state=%0d, want 4", bus.mode_state);
        end
        bus.mode_busy = 1'b0;
        steps(8);
        checks++;
        if (bus.mode_state !== 3'd4) begin
            errors++;
            $display("FAIL busy_not_queued: state=%0d, want 4", bus.mode_state);
        end
        bus.btn_back = 1'b1;
        steps(7);
        checks++;
        if (bus.mode_state !== 3'd4) begin
            errors++;
            $display("FAIL back_edge6: state=%0d, want 4", bus.mode_state);
        end
        step();
        checks++;
        if (bus.mode_state !== 3'd0 || bus.mode_enter !== 1'b0) begin
            errors++;
            $display("FAIL back_edge7: state=%0d enter=%0b, want 0/0", bus.mode_state, bus.mode_enter);
        end
        bus.btn_back = 1'b0;
        steps(6);
        checks++;
        if (mm !== 0) begin
            errors++;
            $display("FAIL model_busy: %0d cycles off, first act=%b exp=%b", mm, mm_act, mm_exp);
        end
        mm = 0;
    endtask

    task automatic test_done_collision();
        int odd;
        enter_mode(3'd2);
        bus.mode_done = 1'b1;
        step();
        bus.mode_done = 1'b0;
        checks++;
        if (bus.mode_state !== 3'd0 || bus.mode_enter !== 1'b0) begin
            errors++;
            $display("FAIL done_return: state=%0d enter=%0b, want 0/0", bus.mode_state, bus.mode_enter);
        end
        steps(2);
        enter_mode(3'd2);
        bus.btn_back = 1'b1;
        steps(7);
        bus.mode_done = 1'b1;
        step();
        bus.mode_done = 1'b0;
        checks++;
        if (bus.mode_state !== 3'd0 || bus.mode_enter !== 1'b0) begin
            errors++;
            $display("FAIL collide_return: state=%0d enter=%0b, want 0/0", bus.mode_state, bus.mode_enter);
        end
        odd = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (dut_vec() !== 5'b0) odd++;
        end
        bus.btn_back = 1'b0;
        checks++;
        if (odd !== 0) begin
            errors++;
            $display("FAIL collide_single: %0d odd cycles after return, want 0", odd);
        end
        enter_mode(3'd2);
        bus.sw_sel = 3'd5;
        steps(3);
        odd = 0;
        bus.btn_confirm = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            odd += int'(bus.mode_enter);
        end
        bus.btn_confirm = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            odd += int'(bus.mode_enter);
        end
        checks++;
        if (bus.mode_state !== 3'd2 || odd !== 0) begin
            errors++;
            $display("FAIL confirm_ignored: state=%0d enters=%0d, want 2 and 0", bus.mode_state, odd);
        end
        checks++;
        if (mm !== 0) begin
            errors++;
            $display("FAIL model_done: %0d cycles off, first act=%b exp=%b", mm, mm_act, mm_exp);
        end
        mm = 0;
    endtask

    task automatic test_reset_mid();
        bus.mode_done = 1'b1;
        step();
        bus.mode_done = 1'b0;
        step();
        enter_mode(3'd5);
        checks++;
        if (bus.mode_state !== 3'd5) begin
            errors++;
            $display("FAIL mid_enter: state=%0d, want 5", bus.mode_state);
        end
        bus.mode_busy = 1'b0;
        bus.btn_back  = 1'b1;
        steps(4);
        bus.sw_sel      = 3'd1;
        bus.btn_confirm = 1'b1;
        rst             = 1'b1;
        step();
        checks++;
        if (dut_vec() !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b, want 00000", dut_vec());
        end
        step();
        rst = 1'b0;
        steps(7);
        checks++;
        if (bus.mode_state !== 3'd0) begin
            errors++;
            $display("FAIL held_edge6: state=%0d, want 0", bus.mode_state);
        end
        step();
        checks++;
        if (bus.mode_state !== 3'd1 || bus.mode_enter !== 1'b1) begin
            errors++;
            $display("FAIL held_edge7: state=%0d enter=%0b, want 1/1", bus.mode_state, bus.mode_enter);
        end
        bus.btn_confirm = 1'b0;
        bus.btn_back    = 1'b0;
        steps(8);
        checks++;
        if (mm !== 0) begin
            errors++;
            $display("FAIL model_reset_mid: %0d cycles off, first act=%b exp=%b", mm, mm_act, mm_exp);
        end
        mm = 0;
    endtask

    task automatic test_random();
        int run_c, run_b, run_busy;
        run_c = 0;
        run_b = 0;
        run_busy = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (run_c == 0) begin
                bus.btn_confirm = 1'($urandom_range(0, 1));
                run_c = int'($urandom_range(1, 10));
            end
            if (run_b == 0) begin
                bus.btn_back = 1'($urandom_range(0, 1));
                run_b = int'($urandom_range(1, 10));
            end
            if (run_busy == 0) begin
                bus.mode_busy = 1'($urandom_range(0, 1));
                run_busy = int'($urandom_range(5, 40));
            end
            run_c--;
            run_b--;
            run_busy--;
            if ($urandom_range(0, 15) == 0) bus.sw_sel = 3'($urandom_range(0, 7));
            bus.mode_done = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 499) == 0);
            @(posedge clk);
            #1;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: {state,enter,err} got %b, model %b", cyc, dut_vec(), mdl_vec());
            end
        end
        bus.mode_done = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.btn_confirm = 1'b0;
        bus.btn_back    = 1'b0;
        bus.sw_sel      = 3'd0;
        bus.mode_busy   = 1'b0;
        bus.mode_done   = 1'b0;
        test_reset();
        test_legal_entry();
        test_glitch_illegal();
        test_busy_back();
        test_done_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
